// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg
//   Types and sizing constants shared by the SNN weight-path blocks.
//   - wl_state_t    : weight_loader controller states
//   - WEIGHT_DEPTH  : words per weight load (register file depth)
//   - WEIGHT_ADDR_W : weight register file address width
//   - WEIGHT_DATA_W : weight word width
// ----------------------------------------------------------------------------
package snn_pkg;

   localparam int unsigned WEIGHT_DEPTH  = 256;
   localparam int unsigned WEIGHT_ADDR_W = 8;
   localparam int unsigned WEIGHT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } wl_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// ----------------------------------------------------------------------------
// weight_loader_if
//   Weight stream input plus weight-storage write port.
//   Stream : in_valid, in_data (producer -> loader), in_ready (loader -> producer)
//   Write  : W_Addr, W_en, W_Data (loader -> storage)
//   Modports: slave  = loader side (consumes stream, drives write port)
//             master = producer/storage side
// ----------------------------------------------------------------------------
interface weight_loader_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] W_Addr;
   logic              W_en;
   logic [DATA_W-1:0] W_Data;

   modport slave (
      input  in_valid, in_data,
      output in_ready, W_Addr, W_en, W_Data
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, W_Addr, W_en, W_Data
   );

endinterface

// File: rtl/weight_chksum.sv
// ----------------------------------------------------------------------------
// weight_chksum
//   Running modulo-2^DATA_W sum of accepted weight bytes.
//   Only present when WEIGHT_LOADER_CHECKSUM_EN is defined.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     clr      : restart the sum at zero (wins over acc)
//     acc      : add din into the sum this cycle
//     din      : byte to accumulate
//     sum      : registered running sum
// ----------------------------------------------------------------------------
`ifdef WEIGHT_LOADER_CHECKSUM_EN
module weight_chksum #(
   parameter int unsigned DATA_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              acc,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (acc) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule
`endif

// File: rtl/weight_loader.sv
// ----------------------------------------------------------------------------
// weight_loader
//   Streams DEPTH weight words into the weight register file at sequential
//   addresses starting at 0, one write per accepted byte, issued the cycle
//   after the handshake. Signals done once the full set has been written.
//   Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN adds a trailer byte that
//   must equal the modulo-256 sum of the DEPTH data bytes (chk_err on mismatch).
//   Ports:
//     Clk, Rst : clock, synchronous active-high reset
//     start    : begin a load (only honoured when idle)
//     abort    : cancel the running load, no done
//     wbus     : stream in (in_valid/in_data/in_ready) and write port
//                (W_Addr/W_en/W_Data)
//     busy     : load in progress
//     done     : one-cycle completion pulse
//     chk_err  : checksum mismatch, held until next start (0 when macro off)
// ----------------------------------------------------------------------------
module weight_loader
   import snn_pkg::*;
#(
   parameter int unsigned DEPTH  = WEIGHT_DEPTH,
   parameter int unsigned ADDR_W = WEIGHT_ADDR_W,
   parameter int unsigned DATA_W = WEIGHT_DATA_W
)(
   input  logic           Clk,
   input  logic           Rst,
   input  logic           start,
   input  logic           abort,
   weight_loader_if.slave wbus,
   output logic           busy,
   output logic           done,
   output logic           chk_err
);

   // One extra counter bit so DEPTH = 2^ADDR_W does not alias to 0.
   localparam int unsigned     CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   wl_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              chk_err_q, chk_err_d;
   logic              in_ready;
   logic              hs;

   // Ready depends on registered state only, never on in_valid.
   assign in_ready = (state_q == LOAD) || (state_q == CHECK);
   assign hs       = wbus.in_valid && in_ready;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;
   logic              sum_clr;
   logic              sum_acc;

   weight_chksum #(
      .DATA_W (DATA_W)
   ) u_chksum (
      .clk (Clk),
      .rst (Rst),
      .clr (sum_clr),
      .acc (sum_acc),
      .din (wbus.in_data),
      .sum (sum)
   );
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      waddr_d   = waddr_q;
      wen_d     = 1'b0;
      wdata_d   = wdata_q;
      chk_err_d = chk_err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_clr   = 1'b0;
      sum_acc   = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               cnt_d     = '0;
               chk_err_d = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
               sum_clr   = 1'b1;
`endif
            end
         end
         LOAD: begin
            if (hs) begin
               wen_d   = 1'b1;
               waddr_d = cnt_q[ADDR_W-1:0];
               wdata_d = wbus.in_data;
               cnt_d   = cnt_q + CNT_W'(1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
               sum_acc = 1'b1;
               if (cnt_q == LAST) state_d = CHECK;
`else
               if (cnt_q == LAST) state_d = DONE;
`endif
            end
            // A write captured on the abort cycle still goes out; only the
            // state is cancelled.
            if (abort) state_d = IDLE;
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
            end else if (hs) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
               chk_err_d = (wbus.in_data != sum);
`endif
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // DONE always lasts one cycle, so entering it yields a single pulse.
      done_d = (state_d == DONE);
      busy_d = (state_d == LOAD) || (state_d == CHECK);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         waddr_q   <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         chk_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         waddr_q   <= waddr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         chk_err_q <= chk_err_d;
      end
   end

   assign wbus.in_ready = in_ready;
   assign wbus.W_Addr   = waddr_q;
   assign wbus.W_en     = wen_q;
   assign wbus.W_Data   = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
   assign chk_err       = chk_err_q;
`else
   assign chk_err       = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// ----------------------------------------------------------------------------
// tb_weight_loader
//   Randomized self-checking bench for weight_loader against a behavioural
//   model of the load protocol (accepted-byte count, running sum, expected
//   write/done/busy per cycle). Honors WEIGHT_LOADER_CHECKSUM_EN.
// ----------------------------------------------------------------------------
module tb_weight_loader;

   localparam int unsigned DEPTH  = 256;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Rst, start, abort;
   logic busy, done, chk_err;

   always #5 Clk = ~Clk;

   weight_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   weight_loader #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .start   (start),
      .abort   (abort),
      .wbus    (bus.slave),
      .busy    (busy),
      .done    (done),
      .chk_err (chk_err)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   // model: what a loader must show after each clock edge
   bit                m_act  = 1'b0;
   bit                m_trl  = 1'b0;
   int unsigned       m_acc  = 0;
   logic [DATA_W-1:0] m_sum  = '0;
   logic              e_wen  = 1'b0;
   logic [ADDR_W-1:0] e_waddr = '0;
   logic [DATA_W-1:0] e_wdata = '0;
   logic              e_done = 1'b0;
   logic              e_err  = 1'b0;

   logic [DATA_W-1:0] exp_bytes [DEPTH];
   logic [DATA_W-1:0] tb_mem    [DEPTH];
   int unsigned       cyc = 0;
   int unsigned       wr_obs, done_seen, done_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare all outputs.
   task automatic cycle(input bit r, input bit st, input bit ab, input bit v,
                        input logic [DATA_W-1:0] d);
      bit idle_ok;
      Rst          = r;
      start        = st;
      abort        = ab;
      bus.in_valid = v;
      bus.in_data  = d;

      idle_ok = !m_act && !e_done;
      e_wen   = 1'b0;
      e_done  = 1'b0;
      if (r) begin
         m_act   = 1'b0;
         m_trl   = 1'b0;
         e_waddr = '0;
         e_wdata = '0;
         e_err   = 1'b0;
      end else if (m_act) begin
         if (v) begin
            if (!m_trl) begin
               e_wen            = 1'b1;
               e_waddr          = ADDR_W'(m_acc);
               e_wdata          = d;
               exp_bytes[m_acc] = d;
               m_sum            = m_sum + d;
               m_acc++;
               if (m_acc == DEPTH) begin
                  if (CHK) m_trl = 1'b1;
                  else begin
                     m_act  = 1'b0;
                     e_done = 1'b1;
                  end
               end
            end else if (!ab) begin
               e_err  = (d != m_sum);
               m_act  = 1'b0;
               m_trl  = 1'b0;
               e_done = 1'b1;
            end
         end
         if (ab) begin
            m_act  = 1'b0;
            m_trl  = 1'b0;
            e_done = 1'b0;
         end
      end else if (idle_ok && st) begin
         m_act = 1'b1;
         m_trl = 1'b0;
         m_acc = 0;
         m_sum = '0;
         e_err = 1'b0;
      end

      @(posedge Clk);
      @(negedge Clk);
      cyc++;

      chk("in_ready", bus.in_ready, m_act);
      chk("w_en",     bus.W_en,     e_wen);
      chk("w_addr",   bus.W_Addr,   e_waddr);
      chk("w_data",   bus.W_Data,   e_wdata);
      chk("busy",     busy,         m_act);
      chk("done",     done,         e_done);
      chk("chk_err",  chk_err,      e_err);

      if (bus.W_en === 1'b1) begin
         tb_mem[bus.W_Addr] = bus.W_Data;
         wr_obs++;
      end
      if (done === 1'b1) begin
         done_seen++;
         done_cyc = cyc;
      end
   endtask

   // vmode: 0 full rate, 1 every 3rd cycle, 2 random bubbles
   // dmode: 0 index bytes, 1 all 0x01, 2 random
   // tmode: 0 correct trailer, 1 wrong trailer, 2 random
   task automatic load(input int unsigned vmode, input int abort_at, input int rst_at,
                       input int unsigned tmode, input int unsigned dmode, input bit rnd_start);
      int unsigned       c0;
      bit                v, st, ab, r;
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DEPTH; i++) tb_mem[i] = 'x;
      wr_obs    = 0;
      done_seen = 0;
      c0        = cyc;
      cycle(1'b0, 1'b1, 1'b0, vmode == 0, '0);
      for (int unsigned n = 0; n < 4 * DEPTH + 16 && m_act; n++) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (n % 3 == 2);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         if (m_acc < DEPTH) begin
            case (dmode)
               0:       d = DATA_W'(m_acc);
               1:       d = 8'h01;
               default: d = DATA_W'($urandom);
            endcase
         end else begin
            case (tmode)
               0:       d = m_sum;
               1:       d = m_sum + 8'h01;
               default: d = $urandom_range(0, 1) ? m_sum : DATA_W'($urandom);
            endcase
         end
         ab = (abort_at >= 0) && (m_acc == abort_at);
         r  = (rst_at >= 0) && (m_acc == rst_at);
         if (ab && vmode != 2) v = 1'b0;
         if (r) v = 1'b1;
         st = rnd_start && ($urandom_range(0, 7) == 0);
         cycle(r, st, ab, v, d);
      end
      if (m_act) chk("timeout", 32'd1, 32'd0);
      if (abort_at < 0 && rst_at < 0) begin
         int unsigned mis = 0;
         for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== exp_bytes[i]) mis++;
         chk("mem_mismatch", mis, 0);
         chk("write_count", wr_obs, DEPTH);
         chk("done_count", done_seen, 1);
         if (vmode == 0) chk("done_at", done_cyc - c0, DEPTH + 1 + CHK);
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         cycle(1'b0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1), DATA_W'($urandom));
   endtask

   initial begin
      // reset, then stream activity without start
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DATA_W'(i));

      // full-rate load of 0x00..0xFF
      load(0, -1, -1, 0, 0, 1'b0);
      idle(3);

      // every third cycle valid, random data
      load(1, -1, -1, 0, 2, 1'b0);
      idle(2);

      // abort after 10 handshakes, then restart
      load(0, 10, -1, 0, 2, 1'b0);
      chk("abort_writes", wr_obs, 10);
      chk("abort_done", done_seen, 0);
      idle(2);
      load(0, -1, -1, 0, 0, 1'b0);
      idle(2);

      // reset mid-load at address 0x40, then restart
      load(0, -1, 'h40, 0, 2, 1'b0);
      chk("rst_writes", wr_obs, 'h40);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
      load(0, -1, -1, 0, 2, 1'b0);
      idle(2);

      // trailer checks: good then bad, error held through idle
      load(0, -1, -1, 0, 1, 1'b0);
      idle(3);
      load(0, -1, -1, 1, 1, 1'b0);
      idle(5);

      // randomized loads with stray start pulses and occasional aborts
      for (int k = 0; k < 4; k++) begin
         int ab_at;
         ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DEPTH)) : -1;
         load(2, ab_at, -1, 2, 2, 1'b1);
         idle($urandom_range(1, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
